sha256_block_feeder: RTL
========================

// Module: sha256_block_feeder
// PURPOSE
//   Initiator side of the SHA-256 core's start/done interface. Reads a NUM_OF_WORDS-word message
//   from word-addressed memory, applies SHA-256 padding, and splits it into 512-bit blocks.
//   Drives each block with the chaining value into the core. Writes the final 8-word digest
//   back to memory. Sits between the memory controller and one SHA-256 compression core.
// PARAMETERS
//   NUM_OF_WORDS  20  message length in 32-bit words (>=1); bit length L = NUM_OF_WORDS*32
//   ADDR_W        16  memory word-address width
// PORTS
//   clk             in   1        clock
//   reset_n         in   1        async active-low reset
//   start           in   1        1-cycle pulse: begin job (ignored unless IDLE)
//   message_addr    in   ADDR_W   word address of message word 0 (sampled on start)
//   output_addr     in   ADDR_W   word address for H0 (sampled on start)
//   done            out  1        1-cycle pulse after last digest word written
//   mem_addr        out  ADDR_W   memory address
//   mem_we          out  1        write enable
//   mem_write_data  out  32       write data
//   mem_read_data   in   32       read data, valid 1 cycle after mem_addr presented (mem_we=0)
//   core_start      out  1        1-cycle pulse: core_message/core_hin valid
//   core_message    out  16x32    current block, index 0 = first word
//   core_hin        out  8x32     chaining value, index i = Hi
//   core_hout       in   8x32     core result (already added to hin), index i = Hi
//   core_done       in   1        1-cycle pulse; core_hout valid this cycle
// BEHAVIOUR
//   Reset: state=IDLE; done, mem_we, core_start = 0; mem_addr, mem_write_data = 0;
//     core_message, core_hin = 0. Reset mid-job aborts immediately. No memory write may occur
//     after reset asserts.
//   NUM_BLOCKS = (NUM_OF_WORDS+2)/16 + 1 (integer). The padded stream is: message words, then
//     32'h80000000, then zeros, then 32'h0 and 32'(L) as the last two words of the last block.
//   FSM: IDLE -start-> INIT (core_hin <= H0..H7 SHA-256 IVs 6a09e667..5be0cd19; block=0)
//     -> READ: for 16 consecutive cycles, emits the next padded word into slot n. A message word
//        comes from memory: mem_addr = message_addr + block*16 + n, captured 1 cycle later.
//        Reads are pipelined, 1 word/cycle. Pad words are generated locally with no memory
//        access. READ lasts 17 cycles when the block contains memory words, otherwise 16.
//     -> ISSUE: core_start=1 for exactly one cycle; core_message/core_hin held stable until
//        core_done.
//     -> WAIT: on core_done, core_hin <= core_hout; block++.
//        If block < NUM_BLOCKS-1: go to READ. Otherwise go to WRITE.
//     -> WRITE: 8 cycles; mem_we=1, mem_addr=output_addr+i, mem_write_data=Hi, i=0..7.
//     -> DONE: done=1 for one cycle -> IDLE.
//   start is ignored outside IDLE. core_done is ignored outside WAIT.
//   All address arithmetic is modulo 2^ADDR_W (wraps silently).
//   Boundary: when NUM_OF_WORDS%16 is 14 or 15, the 0x80 word and/or the length words spill
//     into an extra all-pad block; that block performs no memory reads.
//   Core latency is not assumed; WAIT holds indefinitely until core_done.
// CONFIGURATION
//   SHA_FEEDER_BYTESWAP_EN defined: every word read from memory is byte-reversed
//     ({b0,b1,b2,b3}) before padding. Digest words are also byte-reversed before writing.
//     This supports little-endian memory images.
//   Undefined: words pass through unchanged (big-endian, SHA-256 native order).
//   Pad and length words are never swapped.
// TESTING
//   1 NUM_OF_WORDS=1, mem[0]=32'h61626364 ("abcd"), real core -> one block; mem[out..out+7] =
//     88d4266f d4e6338d 13b845fc f289579d 209c8978 23b9217d a3e16193 6f031589; done pulses once.
//   2 NUM_OF_WORDS=20, stub core (hout=hin+1 per word) -> 2 core_start pulses. Block 2 word 4
//     is 32'h80000000 and word 15 is 32'd640. The final digest equals IV+2 per word.
//   3 NUM_OF_WORDS=14 -> 2 blocks; block 1 word 14 = 80000000, word 15 = 0.
//     Block 2 is all zero except word 15 = 448; no mem reads are issued during block 2.
//   4 Stub core delays core_done 50 cycles; start pulsed during WAIT -> ignored.
//     Core inputs are stable throughout the wait; exactly one digest is written.
//   5 reset_n low during WRITE after 3 words -> outputs are zero immediately and no further
//     mem_we occurs. A new start then produces the full correct digest.
//   6 SHA_FEEDER_BYTESWAP_EN, mem[0]=32'h64636261, test 1 otherwise -> each written word is
//     the byte-reversed test 1 digest (6f26d488 ...).

Source files
------------

// File: rtl/sha256_block_feeder.sv
// sha256_block_feeder: streams a padded NUM_OF_WORDS-word message through one SHA-256 core
// and writes the digest back to memory.
//   clk, reset_n          clock, async active-low reset
//   start                 begin a job (IDLE only); samples message_addr and output_addr
//   done                  one-cycle pulse after the last digest word is written
//   mem_*                 word-addressed memory port, read data one cycle after mem_addr
//   core_start/core_done  block handshake with the compression core
//   core_message/core_hin block words and chaining value; core_hout is the core result
// Optional: SHA_FEEDER_BYTESWAP_EN byte-reverses message words read and digest words written.
module sha256_block_feeder #(
  parameter int NUM_OF_WORDS = 20,
  parameter int ADDR_W = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       message_addr,
  input  logic [ADDR_W-1:0]       output_addr,
  output logic                    done,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    mem_we,
  output logic [31:0]             mem_write_data,
  input  logic [31:0]             mem_read_data,
  output logic                    core_start,
  output logic [15:0][31:0]       core_message,
  output logic [7:0][31:0]        core_hin,
  input  logic [7:0][31:0]        core_hout,
  input  logic                    core_done
);
  localparam logic [2:0] IDLE = 3'd0, INIT = 3'd1, READ = 3'd2, ISSUE = 3'd3,
                         WAIT = 3'd4, WRITE = 3'd5, DONE = 3'd6;
  localparam logic [31:0] NW = 32'(NUM_OF_WORDS);
  localparam logic [31:0] NB = 32'((NUM_OF_WORDS + 2) / 16 + 1);
  localparam logic [31:0] LAST = NB * 16 - 1;
  localparam logic [31:0] LEN = 32'(NUM_OF_WORDS * 32);
  localparam logic [7:0][31:0] IV = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                     32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
  function automatic logic [31:0] sw(input logic [31:0] w);
`ifdef SHA_FEEDER_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction
  logic [2:0] state;
  logic [31:0] blk, g, pad;
  logic [4:0] n;
  logic [3:0] wi, cap_slot;
  logic [ADDR_W-1:0] maddr, oaddr;
  logic cap_v, cur_mem, next_mem, has_mem, nblk_mem;
  always_comb begin
    g = (blk << 4) + {27'd0, n};
    cur_mem = g < NW;
    next_mem = (n < 5'd15) && (g + 1 < NW);
    has_mem = (blk << 4) < NW;
    nblk_mem = ((blk + 1) << 4) < NW;
    pad = (g == NW) ? 32'h80000000 : (g == LAST) ? LEN : 32'h0;
  end
  // Addresses are presented one slot ahead so each memory word lands one cycle after its slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      done <= 1'b0;
      mem_addr <= '0;
      mem_we <= 1'b0;
      mem_write_data <= '0;
      core_start <= 1'b0;
      core_message <= '0;
      core_hin <= '0;
      blk <= '0;
      n <= '0;
      wi <= '0;
      cap_slot <= '0;
      cap_v <= 1'b0;
      maddr <= '0;
      oaddr <= '0;
    end else begin
      cap_v <= 1'b0;
      if (cap_v) core_message[cap_slot] <= sw(mem_read_data);
      case (state)
        IDLE: if (start) begin
          maddr <= message_addr;
          oaddr <= output_addr;
          state <= INIT;
        end
        INIT: begin
          core_hin <= IV;
          blk <= '0;
          n <= '0;
          mem_addr <= maddr;
          state <= READ;
        end
        READ: begin
          if (n < 5'd16) begin
            if (cur_mem) begin
              cap_v <= 1'b1;
              cap_slot <= n[3:0];
            end else core_message[n[3:0]] <= pad;
            if (next_mem) mem_addr <= maddr + ADDR_W'(g + 1);
          end
          if ((n == 5'd15 && !has_mem) || n == 5'd16) begin
            core_start <= 1'b1;
            state <= ISSUE;
          end else n <= n + 5'd1;
        end
        ISSUE: begin
          core_start <= 1'b0;
          state <= WAIT;
        end
        WAIT: if (core_done) begin
          core_hin <= core_hout;
          blk <= blk + 1;
          if (blk < NB - 1) begin
            n <= '0;
            if (nblk_mem) mem_addr <= maddr + ADDR_W'((blk + 1) << 4);
            state <= READ;
          end else begin
            mem_we <= 1'b1;
            mem_addr <= oaddr;
            mem_write_data <= sw(core_hout[0]);
            wi <= 4'd1;
            state <= WRITE;
          end
        end
        WRITE: if (wi == 4'd8) begin
          mem_we <= 1'b0;
          done <= 1'b1;
          state <= DONE;
        end else begin
          mem_addr <= oaddr + ADDR_W'(wi);
          mem_write_data <= sw(core_hin[wi[2:0]]);
          wi <= wi + 4'd1;
        end
        DONE: begin
          done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
